// File: rtl/proc_stage_sequencer_if.sv
// Control-path bundle between the stage sequencer, the control unit and memory.
// master drives run control, the decode fields and MEM_READY; slave is the sequencer.
interface proc_stage_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             EN;
  logic [5:0]       OPCODE;
  logic [5:0]       FUNCT;
  logic             MEM_READY;
  logic [2:0]       STATE;
  logic             MEM_READ;
  logic             MEM_WRITE;
  logic             STALL;
  logic             RETIRE;
  logic [CNT_W-1:0] RETIRED_CNT;
  logic             ERR_TIMEOUT;

  modport master (
    output EN, OPCODE, FUNCT, MEM_READY,
    input  STATE, MEM_READ, MEM_WRITE, STALL, RETIRE, RETIRED_CNT, ERR_TIMEOUT
  );

  modport slave (
    input  EN, OPCODE, FUNCT, MEM_READY,
    output STATE, MEM_READ, MEM_WRITE, STALL, RETIRE, RETIRED_CNT, ERR_TIMEOUT
  );
endinterface

// File: rtl/proc_stage_sequencer.sv
// Multi-cycle stage sequencer: FETCH/DECODE/EXE/MEM/WB with memory-ready waits and timeout.
// Outputs are registered next-state decodes; FETCH and memory MEM hold until MEM_READY, else HALT.
module proc_stage_sequencer #(
  parameter int MUL_LAT      = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4,
  parameter int CNT_W        = 32
) (
  input logic                   CLK,
  input logic                   RST,
  proc_stage_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXE    = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_HALT   = 3'b110
  } state_e;

  localparam int TO_LIM_I  = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
  localparam int MUL_LIM_I = (MUL_LAT > 0) ? MUL_LAT - 1 : 0;
  localparam logic [WAIT_W-1:0] TO_LIM  = WAIT_W'(TO_LIM_I);
  localparam logic [WAIT_W-1:0] MUL_LIM = WAIT_W'(MUL_LIM_I);

  function automatic logic is_mul(input logic [5:0] op, input logic [5:0] fn);
    return ((op == 6'h00) && (fn == 6'h2c)) || (op == 6'h1d);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h1c);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == 6'h2b) || (op == 6'h1b);
  endfunction

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [5:0]        op_q, op_d;
  logic              mul_q, mul_d;
  logic              mem_read_q, mem_write_q, stall_q, retire_q, err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;
  logic              memop_d;

  // Saturate so a no-timeout wait keeps reporting STALL instead of wrapping to 0.
  assign wait_inc    = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
  assign timeout_hit = (MEM_WAIT_MAX != 0) && (wait_q == TO_LIM);
  assign memop_d     = is_load(op_d) || is_store(op_d);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    mul_d   = mul_q;
    case (state_q)
      S_IDLE: begin
        if (bus.EN) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (bus.MEM_READY)    state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
        else                  wait_d  = wait_inc;
      end
      S_DECODE: begin
        op_d    = bus.OPCODE;
        mul_d   = is_mul(bus.OPCODE, bus.FUNCT);
        state_d = S_EXE;
        wait_d  = '0;
      end
      S_EXE: begin
        if (mul_q && (wait_q != MUL_LIM)) begin
          wait_d = wait_inc;
        end else begin
          state_d = S_MEM;
          wait_d  = '0;
        end
      end
      S_MEM: begin
        if (!(is_load(op_q) || is_store(op_q))) state_d = S_WB;
        else if (bus.MEM_READY)                state_d = S_WB;
        else if (timeout_hit)                  state_d = S_HALT;
        else                                   wait_d  = wait_inc;
      end
      S_WB: begin
        if (bus.EN) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      op_q        <= '0;
      mul_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      stall_q     <= 1'b0;
      retire_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      op_q        <= op_d;
      mul_q       <= mul_d;
      mem_read_q  <= (state_d == S_FETCH) || ((state_d == S_MEM) && is_load(op_d));
      mem_write_q <= (state_d == S_MEM) && is_store(op_d);
      // Wait stages report STALL once they have actually been held a cycle.
      stall_q     <= (((state_d == S_FETCH) || ((state_d == S_MEM) && memop_d)) && (wait_d != '0))
                  || ((state_d == S_EXE) && mul_d && (wait_d != MUL_LIM));
      retire_q    <= (state_d == S_WB);
      err_q       <= err_q || (state_d == S_HALT);
      if (state_d == S_WB) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.STATE       = state_q;
  assign bus.MEM_READ    = mem_read_q;
  assign bus.MEM_WRITE   = mem_write_q;
  assign bus.STALL       = stall_q;
  assign bus.RETIRE      = retire_q;
  assign bus.RETIRED_CNT = cnt_q;
  assign bus.ERR_TIMEOUT = err_q;

endmodule
